treasure_reporter: RTL and testbench
====================================

TREASURE_REPORTER -- requirements
Module: treasure_reporter

Interface
REQ-001 SHALL have parameter CODE_W, default 3, meaning width of the classification code.
REQ-002 SHALL have parameter VOTE_FRAMES, default 4, meaning consecutive identical frames required for a stable code (range 1..15).
REQ-003 SHALL have parameter BIT_CYCLES, default 50, meaning CLK cycles per TX_CLK phase (high or low), minimum 1.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 65535, meaning CLK cycles to wait for ACK before abort.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 CLK  input  1  sole clock, all state updates on rising edge.
REQ-007 RESET  input  1  synchronous active-high reset.
REQ-008 RESULT_IN  input  CODE_W  per-frame classification from the image processor.
REQ-009 FRAME_DONE  input  1  single-cycle pulse; RESULT_IN valid in the same cycle.
REQ-010 ACK  input  1  asynchronous acknowledge from the Arduino.
REQ-011 TX_REQ  output  1  high for the whole transfer.
REQ-012 TX_CLK  output  1  serial bit clock; receiver samples TX_DATA on its rising edge.
REQ-013 TX_DATA  output  1  serial data, MSB first.
REQ-014 STABLE_CODE  output  CODE_W  last code that passed the vote filter.
REQ-015 BUSY  output  1  high in every state except IDLE.
REQ-016 ERR  output  1  sticky flag: ACK timeout occurred.

Function
REQ-017 ACK SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle latency).
REQ-018 On FRAME_DONE: if RESULT_IN equals the candidate, vote counter increments, saturating at VOTE_FRAMES; otherwise candidate <= RESULT_IN and counter <= 1.
REQ-019 The cycle the counter equals VOTE_FRAMES with candidate != STABLE_CODE, STABLE_CODE <= candidate and pending <= 1.
REQ-020 Voting SHALL proceed in every FSM state; a new stable code while BUSY re-sets pending, and only the latest code is sent next.
REQ-021 FSM states: IDLE, SHIFT_HI, SHIFT_LO, WAIT_ACK, WAIT_REL.
REQ-022 IDLE: if pending, latch STABLE_CODE into the shift register, clear pending, TX_REQ <= 1, go to SHIFT_LO with bit index at the MSB. If a new stable code and a start occur in the same cycle, the newly updated value is latched and pending stays 0.
REQ-023 SHIFT_LO: TX_CLK = 0, TX_DATA = current bit, hold BIT_CYCLES cycles, then go to SHIFT_HI.
REQ-024 SHIFT_HI: TX_CLK = 1, TX_DATA held, hold BIT_CYCLES cycles; then go to SHIFT_LO on the next bit, or to WAIT_ACK after the last bit.
REQ-025 WAIT_ACK: TX_CLK = 0. On synchronized ACK = 1, TX_REQ <= 0 and go to WAIT_REL. After ACK_TIMEOUT cycles without ACK, set ERR, TX_REQ <= 0, go to IDLE, and do not re-set pending.
REQ-026 WAIT_REL: on synchronized ACK = 0, go to IDLE.
REQ-027 A transfer SHALL take exactly 2*BIT_CYCLES*NBITS cycles from the first SHIFT_LO cycle to WAIT_ACK entry, where NBITS = CODE_W, or CODE_W+1 with parity.
REQ-028 TX_DATA SHALL be 0 outside SHIFT states.
REQ-029 The phase counter SHALL be wide enough for BIT_CYCLES, and the timeout counter wide enough for ACK_TIMEOUT.

Reset
REQ-030 RESET SHALL force IDLE, with TX_REQ=0, TX_CLK=0, TX_DATA=0, BUSY=0, ERR=0, STABLE_CODE=0, candidate=0, vote counter=0, pending=0, and synchronizer flops=0.
REQ-031 RESET asserted mid-transfer SHALL abort the transfer within the same cycle, with no further TX_CLK edges.
REQ-032 Code 0 SHALL be the initial stable code, so a steady code-0 stream produces no transfer.

Configuration
REQ-033 Macro REPORT_PARITY_EN defined: one even-parity bit (XOR of the code bits) is sent after the LSB, giving NBITS = CODE_W+1. Undefined: no parity bit, NBITS = CODE_W, and no parity logic is synthesized.

Verification (CODE_W=3, VOTE_FRAMES=4, BIT_CYCLES=2, ACK_TIMEOUT=20)
REQ-034 Four FRAME_DONE with RESULT_IN=3 -> STABLE_CODE=3 and TX_REQ rises 1 cycle after the 4th pulse; TX_DATA bits 0,1,1 on TX_CLK rising edges; 12 shift cycles (16 with parity, 4th bit 0).
REQ-035 Pattern 3,3,3,1,3,3,3 -> no transfer and STABLE_CODE stays 0; a 4th consecutive 3 -> transfer of 3.
REQ-036 ACK high 5 cycles into WAIT_ACK -> TX_REQ falls 2 cycles later; ACK low -> IDLE 2 cycles later, BUSY=0.
REQ-037 ACK never asserted -> ERR=1 and IDLE after 20 WAIT_ACK cycles; ERR holds until RESET.
REQ-038 Code 5 becomes stable during a transfer of 3 -> 3 completes unchanged, then 5 is sent immediately after WAIT_REL exits.
REQ-039 RESET pulse in SHIFT_HI -> next cycle TX_REQ=0, TX_CLK=0, STABLE_CODE=0, no further edges.

Source files
------------

// File: rtl/treasure_reporter.sv
// treasure_reporter: votes per-frame codes into a stable code and ships each new one over a clocked serial link with ACK handshake.
// Ports: CLK/RESET (sync, active high); RESULT_IN+FRAME_DONE frame results; ACK async receiver acknowledge;
// TX_REQ/TX_CLK/TX_DATA serial link (MSB first, sampled on TX_CLK rise); STABLE_CODE voted code; BUSY not idle; ERR sticky ACK timeout.
// Build option: define REPORT_PARITY_EN to append an even-parity bit after the LSB.
module treasure_reporter #(
  parameter int CODE_W      = 3,
  parameter int VOTE_FRAMES = 4,
  parameter int BIT_CYCLES  = 50,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CODE_W-1:0] RESULT_IN,
  input  logic              FRAME_DONE,
  input  logic              ACK,
  output logic              TX_REQ,
  output logic              TX_CLK,
  output logic              TX_DATA,
  output logic [CODE_W-1:0] STABLE_CODE,
  output logic              BUSY,
  output logic              ERR
);
`ifdef REPORT_PARITY_EN
  localparam int NB = CODE_W + 1;
`else
  localparam int NB = CODE_W;
`endif
  localparam int PW = $clog2(BIT_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int BW = $clog2(NB + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0] VF = 4'(VOTE_FRAMES);
  localparam logic [BW-1:0] BIT_FIRST = BW'(NB - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_HI, SHIFT_LO, WAIT_ACK, WAIT_REL} state_t;

  state_t            state;
  logic [CODE_W-1:0] cand;
  logic [3:0]        votes;
  logic              pending;
  logic [1:0]        ack_sync;
  logic [NB-1:0]     sr;
  logic [PW-1:0]     ph;
  logic [BW-1:0]     bit_left;
  logic [TW-1:0]     to;
  logic              new_stable;
  logic              start;
  logic [CODE_W-1:0] next_code;
  logic [NB-1:0]     word;

  assign new_stable = votes == VF && cand != STABLE_CODE;
  // a code that becomes stable in the same cycle as a start is sent directly
  assign next_code  = new_stable ? cand : STABLE_CODE;
  assign start      = state == IDLE && (pending || new_stable);
`ifdef REPORT_PARITY_EN
  assign word = {next_code, ^next_code};
`else
  assign word = next_code;
`endif
  assign BUSY = state != IDLE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cand        <= '0;
      votes       <= '0;
      pending     <= 1'b0;
      ack_sync    <= '0;
      sr          <= '0;
      ph          <= '0;
      bit_left    <= '0;
      to          <= '0;
      STABLE_CODE <= '0;
      TX_REQ      <= 1'b0;
      TX_CLK      <= 1'b0;
      TX_DATA     <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[0], ACK};
      if (FRAME_DONE) begin
        cand  <= RESULT_IN;
        votes <= RESULT_IN != cand ? 4'd1 : votes == VF ? votes : votes + 4'd1;
      end
      if (new_stable) STABLE_CODE <= cand;
      pending <= start ? 1'b0 : pending | new_stable;
      case (state)
        IDLE: if (start) begin
          sr       <= word << 1;
          TX_DATA  <= word[NB-1];
          TX_REQ   <= 1'b1;
          TX_CLK   <= 1'b0;
          ph       <= '0;
          bit_left <= BIT_FIRST;
          state    <= SHIFT_LO;
        end
        SHIFT_LO: if (ph == PH_LAST) begin
          ph     <= '0;
          TX_CLK <= 1'b1;
          state  <= SHIFT_HI;
        end else ph <= ph + 1'b1;
        SHIFT_HI: if (ph == PH_LAST) begin
          ph     <= '0;
          TX_CLK <= 1'b0;
          if (bit_left == '0) begin
            TX_DATA <= 1'b0;
            to      <= '0;
            state   <= WAIT_ACK;
          end else begin
            TX_DATA  <= sr[NB-1];
            sr       <= sr << 1;
            bit_left <= bit_left - 1'b1;
            state    <= SHIFT_LO;
          end
        end else ph <= ph + 1'b1;
        WAIT_ACK: if (ack_sync[1]) begin
          TX_REQ <= 1'b0;
          state  <= WAIT_REL;
        end else if (to == TO_LAST) begin
          ERR    <= 1'b1;
          TX_REQ <= 1'b0;
          state  <= IDLE;
        end else to <= to + 1'b1;
        WAIT_REL: if (!ack_sync[1]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_treasure_reporter.sv
// tb_treasure_reporter: table-driven and scoreboard checks of treasure_reporter (CODE_W=3, VOTE_FRAMES=4, BIT_CYCLES=2, ACK_TIMEOUT=20).
module tb_treasure_reporter;
  localparam int BC = 2;
`ifdef REPORT_PARITY_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       CLK = 1'b0, RESET = 1'b1, FRAME_DONE = 1'b0, ACK = 1'b0;
  logic [2:0] RESULT_IN = '0;
  logic       TX_REQ, TX_CLK, TX_DATA, BUSY, ERR;
  logic [2:0] STABLE_CODE;

  treasure_reporter #(.CODE_W(3), .VOTE_FRAMES(4), .BIT_CYCLES(BC), .ACK_TIMEOUT(20)) dut (
    .CLK(CLK), .RESET(RESET), .RESULT_IN(RESULT_IN), .FRAME_DONE(FRAME_DONE), .ACK(ACK),
    .TX_REQ(TX_REQ), .TX_CLK(TX_CLK), .TX_DATA(TX_DATA), .STABLE_CODE(STABLE_CODE),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, xfers = 0, nbits = 0;
  logic [2:0] exp_q[$];
  logic [NB-1:0] rx = '0;
  logic prev_tx_clk = 1'b0;

  function automatic logic [NB-1:0] exp_word(input logic [2:0] c);
`ifdef REPORT_PARITY_EN
    return {c, ^c};
`else
    return c;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // receiver model: samples TX_DATA on each TX_CLK rise, compares whole words against the queue
  always @(negedge CLK) begin
    if (RESET) nbits = 0;
    else if (TX_CLK && !prev_tx_clk) begin
      rx = (rx << 1) | NB'(TX_DATA);
      nbits++;
      if (nbits == NB) begin
        nbits = 0;
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %0h expected no transfer", rx);
        end else check("sb_word", 32'(rx), 32'(exp_word(exp_q.pop_front())));
      end
    end
    prev_tx_clk = TX_CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic pick(input int sel);
    return sel == 0 ? TX_REQ : sel == 1 ? BUSY : TX_CLK;
  endfunction

  task automatic wait_for(input int sel, input logic val, input string name);
    int n = 0;
    while (pick(sel) !== val && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected signal %0d == %0b", name, sel, val);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    ACK = 1'b0;
    FRAME_DONE = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] c);
    RESULT_IN = c;
    FRAME_DONE = 1'b1;
    tick();
    FRAME_DONE = 1'b0;
  endtask

  task automatic handshake();
    int n = 0;
    int x0 = xfers;
    while (xfers == x0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL hs_bits: got timeout expected %0d serial bits", NB);
    end
    repeat (BC + 2) tick();
    ACK = 1'b1;
    wait_for(0, 1'b0, "hs_req_fall");
    ACK = 1'b0;
    wait_for(1, 1'b0, "hs_idle");
  endtask

  typedef struct {
    int              n;
    logic [7:0][2:0] codes;
    logic [2:0]      stable;
    logic            tx;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 1'b0};
    tbl[1] = '{4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3}, 3'd3, 1'b1};
    tbl[2] = '{7, {3'd0, 3'd3, 3'd3, 3'd3, 3'd1, 3'd3, 3'd3, 3'd3}, 3'd0, 1'b0};
    tbl[3] = '{8, {3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd3, 3'd3, 3'd3}, 3'd3, 1'b1};
    tbl[4] = '{4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd6}, 3'd6, 1'b1};
    tbl[5] = '{4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd2, 3'd1}, 3'd0, 1'b0};
    tbl[6] = '{3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7}, 3'd0, 1'b0};
    tbl[7] = '{6, {3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5}, 3'd5, 1'b1};

    do_reset();
    check("rst_tx_req", 32'(TX_REQ), 0);
    check("rst_tx_clk", 32'(TX_CLK), 0);
    check("rst_tx_data", 32'(TX_DATA), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_err", 32'(ERR), 0);
    check("rst_stable", 32'(STABLE_CODE), 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (tbl[v].tx) exp_q.push_back(tbl[v].stable);
      for (int i = 0; i < tbl[v].n; i++) begin
        pulse(tbl[v].codes[i]);
        tick();
      end
      tick();
      check($sformatf("vec%0d_stable", v), 32'(STABLE_CODE), 32'(tbl[v].stable));
      check($sformatf("vec%0d_tx_req", v), 32'(TX_REQ), 32'(tbl[v].tx));
      if (tbl[v].tx) handshake();
    end

    // start latency, bit timing and ACK handshake latency
    do_reset();
    exp_q.push_back(3'd3);
    repeat (4) pulse(3'd3);
    check("lat_req_early", 32'(TX_REQ), 0);
    tick();
    check("lat_req", 32'(TX_REQ), 1);
    check("lat_stable", 32'(STABLE_CODE), 3);
    begin
      int n = 1, falls = 0;
      logic pc = TX_CLK;
      while (falls < NB && n < 200) begin
        tick();
        n++;
        if (pc && !TX_CLK) falls++;
        pc = TX_CLK;
      end
      check("shift_cycles", 32'(n - 1), 32'(2 * BC * NB));
    end
    check("wait_data_low", 32'(TX_DATA), 0);
    repeat (4) tick();
    ACK = 1'b1;
    tick();
    check("ack_sync_req", 32'(TX_REQ), 1);
    tick();
    tick();
    check("ack_req_fall", 32'(TX_REQ), 0);
    check("ack_busy_rel", 32'(BUSY), 1);
    ACK = 1'b0;
    tick();
    check("rel_busy", 32'(BUSY), 1);
    tick();
    tick();
    check("rel_idle", 32'(BUSY), 0);
    check("rel_err", 32'(ERR), 0);

    // ACK timeout: exactly 20 WAIT_ACK cycles, sticky ERR, no retry
    do_reset();
    exp_q.push_back(3'd6);
    repeat (4) pulse(3'd6);
    wait_for(0, 1'b1, "to_req_rise");
    repeat (2 * BC * NB) tick();
    repeat (19) tick();
    check("to_busy_before", 32'(BUSY), 1);
    check("to_err_before", 32'(ERR), 0);
    tick();
    check("to_idle", 32'(BUSY), 0);
    check("to_err", 32'(ERR), 1);
    check("to_req", 32'(TX_REQ), 0);
    repeat (30) tick();
    check("to_err_sticky", 32'(ERR), 1);
    check("to_no_retry", 32'(BUSY), 0);
    do_reset();
    check("to_err_cleared", 32'(ERR), 0);

    // new stable code during a transfer is sent right after it
    do_reset();
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd5);
    repeat (4) pulse(3'd3);
    wait_for(0, 1'b1, "queue_req_rise");
    repeat (4) pulse(3'd5);
    tick();
    check("queue_stable", 32'(STABLE_CODE), 5);
    check("queue_busy", 32'(BUSY), 1);
    handshake();
    tick();
    check("queue_restart", 32'(TX_REQ), 1);
    handshake();

    // reset while TX_CLK is high aborts immediately
    do_reset();
    repeat (4) pulse(3'd3);
    wait_for(2, 1'b1, "abort_clk_hi");
    RESET = 1'b1;
    tick();
    check("abort_req", 32'(TX_REQ), 0);
    check("abort_clk", 32'(TX_CLK), 0);
    check("abort_stable", 32'(STABLE_CODE), 0);
    RESET = 1'b0;
    begin
      int highs = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (TX_CLK) highs++;
      end
      check("abort_no_edges", 32'(highs), 0);
    end

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
